// File: rtl/alu_pkg.sv
// Shared encodings for the execute-stage ALU arbiter: micro-ops, NZCV bit positions,
// FSM states and the operand-register payload.
package alu_pkg;

    localparam int unsigned ALU_DATA_W = 32;
    localparam int unsigned ALU_UOP_W  = 5;
    localparam int unsigned FLAGS_W    = 4;
    localparam int unsigned SHAMT_W    = 5;

    localparam logic [ALU_UOP_W-1:0] UOP_ADD = 5'd1;
    localparam logic [ALU_UOP_W-1:0] UOP_SUB = 5'd2;
    localparam logic [ALU_UOP_W-1:0] UOP_AND = 5'd3;
    localparam logic [ALU_UOP_W-1:0] UOP_XOR = 5'd4;
    localparam logic [ALU_UOP_W-1:0] UOP_CMP = 5'd5;
    localparam logic [ALU_UOP_W-1:0] UOP_LSL = 5'd6;
    localparam logic [ALU_UOP_W-1:0] UOP_LSR = 5'd7;
    localparam logic [ALU_UOP_W-1:0] UOP_MOV = 5'd8;

    localparam int unsigned FLG_Z = 0;
    localparam int unsigned FLG_C = 1;
    localparam int unsigned FLG_N = 2;
    localparam int unsigned FLG_V = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic [ALU_DATA_W-1:0] lhs;
        logic [ALU_DATA_W-1:0] rhs;
        logic [ALU_UOP_W-1:0]  uop;
        logic                  setf;
    } alu_op_t;

    function automatic logic uop_legal(input logic [ALU_UOP_W-1:0] uop);
        return (uop >= UOP_ADD) && (uop <= UOP_MOV);
    endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational 32-bit ALU. SUB/CMP carry means "no borrow"; logic, shift and MOV
// ops clear C and V. MOV passes the right operand through.
module alu_core
    import alu_pkg::*;
(
    input  logic [ALU_DATA_W-1:0] lhs,
    input  logic [ALU_DATA_W-1:0] rhs,
    input  logic [ALU_UOP_W-1:0]  uop,
    output logic [ALU_DATA_W-1:0] res,
    output logic [FLAGS_W-1:0]    flags
);

    logic [ALU_DATA_W:0] sum;
    logic [ALU_DATA_W:0] diff;
    logic                shift_big;
    logic                carry;
    logic                ovf;

    always_comb begin
        sum       = {1'b0, lhs} + {1'b0, rhs};
        diff      = {1'b0, lhs} - {1'b0, rhs};
        shift_big = |rhs[ALU_DATA_W-1:SHAMT_W];
        res       = '0;
        carry     = 1'b0;
        ovf       = 1'b0;
        case (uop)
            UOP_ADD: begin
                res   = sum[ALU_DATA_W-1:0];
                carry = sum[ALU_DATA_W];
                ovf   = (lhs[ALU_DATA_W-1] == rhs[ALU_DATA_W-1]) &&
                        (res[ALU_DATA_W-1] != lhs[ALU_DATA_W-1]);
            end
            UOP_SUB, UOP_CMP: begin
                res   = diff[ALU_DATA_W-1:0];
                carry = ~diff[ALU_DATA_W];
                ovf   = (lhs[ALU_DATA_W-1] != rhs[ALU_DATA_W-1]) &&
                        (res[ALU_DATA_W-1] != lhs[ALU_DATA_W-1]);
            end
            UOP_AND: res = lhs & rhs;
            UOP_XOR: res = lhs ^ rhs;
            // Shift amount is the whole RHS, so anything >= 32 empties the word
            UOP_LSL: res = shift_big ? '0 : (lhs << rhs[SHAMT_W-1:0]);
            UOP_LSR: res = shift_big ? '0 : (lhs >> rhs[SHAMT_W-1:0]);
            UOP_MOV: res = rhs;
            default: res = '0;
        endcase
        flags        = '0;
        flags[FLG_Z] = (res == '0);
        flags[FLG_N] = res[ALU_DATA_W-1];
        flags[FLG_C] = carry;
        flags[FLG_V] = ovf;
    end

endmodule

// File: rtl/alu_rr_grant.sv
// Two-way grant selector. ALU_ARB_RR_EN defined: round-robin with a last_grant
// register (reset to 1 so r0 wins first); undefined: fixed priority, r0 always wins.
module alu_rr_grant (
`ifdef ALU_ARB_RR_EN
    input  logic       clk,
    input  logic       rst_n,
`endif
    input  logic [1:0] req,
    output logic [1:0] gnt
);

`ifdef ALU_ARB_RR_EN
    logic last_grant;

    always_comb begin
        gnt = 2'b00;
        if (req == 2'b11) begin
            gnt = last_grant ? 2'b01 : 2'b10;
        end else if (req[0]) begin
            gnt = 2'b01;
        end else if (req[1]) begin
            gnt = 2'b10;
        end
    end

    // Remember the winner of every grant, contested or not
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
        end else if (|gnt) begin
            last_grant <= gnt[1];
        end
    end
`else
    always_comb begin
        gnt = 2'b00;
        if (req[0]) begin
            gnt = 2'b01;
        end else if (req[1]) begin
            gnt = 2'b10;
        end
    end
`endif

endmodule

// File: rtl/alu_arbiter.sv
// Shares one execute-stage ALU between the execute path (r0) and address generation (r1)
// and owns the NZCV register. Round-robin arbitration when ALU_ARB_RR_EN is defined.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int unsigned          DATA_W    = 32,
    parameter int unsigned          UOP_W     = 5,
    parameter logic [FLAGS_W-1:0]   FLAGS_RST = 4'b0000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               r0_valid,
    output logic               r0_ready,
    input  logic [DATA_W-1:0]  r0_lhs,
    input  logic [DATA_W-1:0]  r0_rhs,
    input  logic [UOP_W-1:0]   r0_uop,
    input  logic               r0_setf,
    input  logic               r1_valid,
    output logic               r1_ready,
    input  logic [DATA_W-1:0]  r1_lhs,
    input  logic [DATA_W-1:0]  r1_rhs,
    input  logic [UOP_W-1:0]   r1_uop,
    input  logic               r1_setf,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic               rsp_id,
    output logic [DATA_W-1:0]  rsp_data,
    output logic [FLAGS_W-1:0] rsp_flags,
    output logic               rsp_err,
    output logic [FLAGS_W-1:0] flags_q
);

    state_t                state;
    alu_op_t               opnd;
    alu_op_t               sel_op;
    logic                  opnd_id;
    logic                  can_grant;
    logic [1:0]            gnt;
    logic [ALU_DATA_W-1:0] alu_res;
    logic [FLAGS_W-1:0]    alu_flags;
    logic                  opnd_legal;
    logic                  commit;

    // A slot opens in IDLE, or in RESP on the cycle the response is taken
    always_comb begin
        can_grant = (state == ST_IDLE) || ((state == ST_RESP) && rsp_ready);
    end

    alu_rr_grant u_grant (
`ifdef ALU_ARB_RR_EN
        .clk   (clk),
        .rst_n (rst_n),
`endif
        .req   ({r1_valid, r0_valid} & {2{can_grant}}),
        .gnt   (gnt)
    );

    assign r0_ready = gnt[0];
    assign r1_ready = gnt[1];

    always_comb begin
        sel_op = '0;
        if (gnt[1]) begin
            sel_op.lhs  = r1_lhs;
            sel_op.rhs  = r1_rhs;
            sel_op.uop  = r1_uop;
            sel_op.setf = r1_setf;
        end else begin
            sel_op.lhs  = r0_lhs;
            sel_op.rhs  = r0_rhs;
            sel_op.uop  = r0_uop;
            sel_op.setf = r0_setf;
        end
    end

    alu_core u_alu (
        .lhs   (opnd.lhs),
        .rhs   (opnd.rhs),
        .uop   (opnd.uop),
        .res   (alu_res),
        .flags (alu_flags)
    );

    always_comb begin
        opnd_legal = uop_legal(opnd.uop);
        commit     = opnd_legal && (opnd.setf || (opnd.uop == UOP_CMP));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            opnd.lhs  <= '0;
            opnd.rhs  <= '0;
            opnd.uop  <= UOP_MOV;
            opnd.setf <= 1'b0;
            opnd_id   <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_data  <= '0;
            rsp_flags <= '0;
            rsp_err   <= 1'b0;
            flags_q   <= FLAGS_RST;
        end else begin
            if (|gnt) begin
                opnd    <= sel_op;
                opnd_id <= gnt[1];
            end
            case (state)
                ST_IDLE: begin
                    if (|gnt) begin
                        state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    rsp_valid <= 1'b1;
                    rsp_id    <= opnd_id;
                    rsp_err   <= ~opnd_legal;
                    rsp_data  <= opnd_legal ? alu_res : '0;
                    rsp_flags <= opnd_legal ? alu_flags : '0;
                    if (commit) begin
                        flags_q <= alu_flags;
                    end
                    state <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= (|gnt) ? ST_EXEC : ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: directed corner cases plus random traffic, with
// expected responses computed from the op definitions using plain integer arithmetic.
module tb_alu_arbiter;

    localparam logic [3:0] FLAGS_RST = 4'b0000;

    typedef struct {
        logic [31:0] lhs;
        logic [31:0] rhs;
        logic [4:0]  uop;
        logic        setf;
    } op_t;

    typedef struct packed {
        logic        id;
        logic [31:0] data;
        logic [3:0]  flags;
        logic        err;
        logic [3:0]  fq;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        r0_valid, r0_ready, r0_setf;
    logic [31:0] r0_lhs, r0_rhs;
    logic [4:0]  r0_uop;
    logic        r1_valid, r1_ready, r1_setf;
    logic [31:0] r1_lhs, r1_rhs;
    logic [4:0]  r1_uop;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_err;
    logic [31:0] rsp_data;
    logic [3:0]  rsp_flags, flags_q;

    always #5 clk = ~clk;

    alu_arbiter #(.DATA_W(32), .UOP_W(5), .FLAGS_RST(FLAGS_RST)) dut (
        .clk(clk), .rst_n(rst_n),
        .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_lhs(r0_lhs), .r0_rhs(r0_rhs),
        .r0_uop(r0_uop), .r0_setf(r0_setf),
        .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_lhs(r1_lhs), .r1_rhs(r1_rhs),
        .r1_uop(r1_uop), .r1_setf(r1_setf),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
        .rsp_flags(rsp_flags), .rsp_err(rsp_err), .flags_q(flags_q)
    );

    // ---------------- reference model ----------------
    function automatic logic sovf(input longint x);
        return (x > 64'sd2147483647) || (x < -64'sd2147483648);
    endfunction

    function automatic void ref_alu(input op_t o, output logic [31:0] d,
                                    output logic [3:0] f, output logic err);
        longint ua, ub, sa, sbv, r;
        logic c, v;
        ua  = longint'({32'd0, o.lhs});
        ub  = longint'({32'd0, o.rhs});
        sa  = longint'($signed(o.lhs));
        sbv = longint'($signed(o.rhs));
        r = 0; c = 1'b0; v = 1'b0; err = 1'b0;
        case (o.uop)
            5'd1: begin r = ua + ub; c = (ua + ub) > 64'sd4294967295; v = sovf(sa + sbv); end
            5'd2, 5'd5: begin r = ua - ub; c = (ua >= ub); v = sovf(sa - sbv); end
            5'd3: r = ua & ub;
            5'd4: r = ua ^ ub;
            5'd6: r = (ub >= 32) ? 64'sd0 : (ua << ub);
            5'd7: r = (ub >= 32) ? 64'sd0 : (ua >> ub);
            5'd8: r = ub;
            default: err = 1'b1;
        endcase
        d = err ? 32'd0 : r[31:0];
        f = err ? 4'd0 : {v, d[31], c, (d == 32'd0)};
    endfunction

    // ---------------- scoreboard / monitor ----------------
    exp_t  scb[$];
    int    nvec = 0;
    int    nerr = 0;
    int    to_flag = 0;
    int    to_seen = 0;
    logic [3:0] mflags = FLAGS_RST;
`ifdef ALU_ARB_RR_EN
    logic  mlast = 1'b1;
`endif
    logic  g1 = 1'b0, g2 = 1'b0, held = 1'b0, any_g, gid;
    exp_t  snap, act, e;
    op_t   gop;
    int    wait_cyc = 0;

    task automatic chk(input string name, input logic [63:0] a, input logic [63:0] x);
        nvec++;
        if (a !== x) begin
            nerr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, a, x, $time);
        end
    endtask

    always @(negedge clk) begin
        if (to_flag != to_seen) begin
            chk("drain_timeout", 64'(to_flag), 64'(to_seen));
            to_seen = to_flag;
        end
        if (!rst_n) begin
            chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
            chk("rst_ready", 64'({r1_ready, r0_ready}), 64'd0);
            chk("rst_rsp_err", 64'(rsp_err), 64'd0);
            chk("rst_rsp_id", 64'(rsp_id), 64'd0);
            chk("rst_rsp_data", 64'(rsp_data), 64'd0);
            chk("rst_rsp_flags", 64'(rsp_flags), 64'd0);
            chk("rst_flags_q", 64'(flags_q), 64'(FLAGS_RST));
            scb.delete();
            mflags = FLAGS_RST;
`ifdef ALU_ARB_RR_EN
            mlast = 1'b1;
`endif
            g1 = 1'b0; g2 = 1'b0; held = 1'b0; wait_cyc = 0;
        end else begin
            any_g = r0_ready | r1_ready;
            chk("ready_onehot", 64'(r0_ready & r1_ready), 64'd0);
            chk("ready_needs_valid", 64'((r0_ready & ~r0_valid) | (r1_ready & ~r1_valid)), 64'd0);
            if (g1) begin
                chk("no_grant_in_exec", 64'(any_g), 64'd0);
                chk("exec_rsp_low", 64'(rsp_valid), 64'd0);
            end else if (rsp_valid && !rsp_ready) begin
                chk("no_grant_while_held", 64'(any_g), 64'd0);
            end else if (r0_valid || r1_valid) begin
`ifdef ALU_ARB_RR_EN
                gid = (r0_valid && r1_valid) ? ~mlast : ~r0_valid;
                mlast = gid;
`else
                gid = ~r0_valid;
`endif
                chk("grant_id", 64'({r1_ready, r0_ready}), gid ? 64'd2 : 64'd1);
                gop = gid ? '{r1_lhs, r1_rhs, r1_uop, r1_setf} : '{r0_lhs, r0_rhs, r0_uop, r0_setf};
                ref_alu(gop, e.data, e.flags, e.err);
                if (!e.err && (gop.setf || gop.uop == 5'd5)) mflags = e.flags;
                e.id = gid;
                e.fq = mflags;
                scb.push_back(e);
            end else begin
                chk("no_spurious_grant", 64'(any_g), 64'd0);
            end
            if (g2) chk("rsp_latency", 64'(rsp_valid), 64'd1);

            act = {rsp_id, rsp_data, rsp_flags, rsp_err, flags_q};
            if (rsp_valid) begin
                if (held) chk("hold_stable", 64'(act), 64'(snap));
                if (rsp_ready) begin
                    if (scb.size() == 0) begin
                        chk("unexpected_rsp", 64'd1, 64'd0);
                    end else begin
                        e = scb.pop_front();
                        chk("rsp_id", 64'(act.id), 64'(e.id));
                        chk("rsp_data", 64'(act.data), 64'(e.data));
                        chk("rsp_flags", 64'(act.flags), 64'(e.flags));
                        chk("rsp_err", 64'(act.err), 64'(e.err));
                        chk("flags_q", 64'(act.fq), 64'(e.fq));
                    end
                end
                held = ~rsp_ready;
                snap = act;
            end else begin
                held = 1'b0;
            end
            if (scb.size() > 0 && !(rsp_valid && rsp_ready)) wait_cyc++;
            else wait_cyc = 0;
            if (wait_cyc > 50) begin
                chk("rsp_timeout", 64'd1, 64'd0);
                wait_cyc = 0;
            end
            g2 = g1;
            g1 = any_g;
        end
    end

    // ---------------- stimulus ----------------
    op_t q0[$], q1[$];
    int unsigned rdy_pct = 100;

    function automatic op_t mk(input logic [31:0] l, input logic [31:0] r,
                               input logic [4:0] u, input logic s);
        op_t o;
        o.lhs = l; o.rhs = r; o.uop = u; o.setf = s;
        return o;
    endfunction

    function automatic logic [31:0] rand_word();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    function automatic op_t rand_op();
        op_t o;
        int unsigned v;
        o.lhs = rand_word();
        o.rhs = rand_word();
        if ($urandom_range(0, 19) < 16) begin
            o.uop = 5'($urandom_range(1, 8));
        end else begin
            v = $urandom_range(0, 23);
            o.uop = (v == 0) ? 5'd0 : 5'(v + 8);
        end
        if ((o.uop == 5'd6 || o.uop == 5'd7) && $urandom_range(0, 1) == 1)
            o.rhs = 32'($urandom_range(0, 40));
        o.setf = 1'($urandom_range(0, 1));
        return o;
    endfunction

    task automatic present();
        r0_valid = (q0.size() > 0);
        if (q0.size() > 0) begin
            r0_lhs = q0[0].lhs; r0_rhs = q0[0].rhs; r0_uop = q0[0].uop; r0_setf = q0[0].setf;
        end
        r1_valid = (q1.size() > 0);
        if (q1.size() > 0) begin
            r1_lhs = q1[0].lhs; r1_rhs = q1[0].rhs; r1_uop = q1[0].uop; r1_setf = q1[0].setf;
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        if (r0_valid && r0_ready && q0.size() > 0) void'(q0.pop_front());
        if (r1_valid && r1_ready && q1.size() > 0) void'(q1.pop_front());
        @(posedge clk);
        #1;
        rsp_ready = ($urandom_range(0, 99) < rdy_pct);
        present();
    endtask

    task automatic drain();
        int n = 0;
        while ((q0.size() > 0 || q1.size() > 0 || scb.size() > 0 || rsp_valid) && n < 300) begin
            cycle();
            n++;
        end
        if (n >= 300) to_flag++;
    endtask

    initial begin
        rst_n = 1'b0;
        rsp_ready = 1'b0;
        r0_valid = 1'b0; r0_lhs = '0; r0_rhs = '0; r0_uop = '0; r0_setf = 1'b0;
        r1_valid = 1'b0; r1_lhs = '0; r1_rhs = '0; r1_uop = '0; r1_setf = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Carry-out to zero, then CMP committing flags without setf
        q0.push_back(mk(32'hFFFF_FFFF, 32'h1, 5'd1, 1'b1));
        drain();
        q1.push_back(mk(32'd5, 32'd7, 5'd5, 1'b0));
        drain();

        // Both requesters saturated with the response always taken
        repeat (4) begin
            q0.push_back(rand_op());
            q1.push_back(rand_op());
        end
        drain();

        // Response held for several clocks while r0 keeps asking
        rdy_pct = 0;
        q0.push_back(mk(32'h7FFF_FFFF, 32'h1, 5'd1, 1'b1));
        q0.push_back(mk(32'h1234_5678, 32'h1, 5'd2, 1'b1));
        repeat (9) cycle();
        rdy_pct = 100;
        drain();

        // Illegal uops and arithmetic/shift boundaries
        q0.push_back(mk(32'hDEAD_BEEF, 32'h1, 5'd12, 1'b1));
        q0.push_back(mk(32'h1, 32'h1, 5'd0, 1'b1));
        q0.push_back(mk(32'h1, 32'h1, 5'd31, 1'b1));
        q0.push_back(mk(32'h8000_0000, 32'h1, 5'd2, 1'b1));
        q0.push_back(mk(32'h8000_0001, 32'd31, 5'd6, 1'b1));
        q0.push_back(mk(32'hFFFF_FFFF, 32'd32, 5'd6, 1'b1));
        q0.push_back(mk(32'hFFFF_FFFF, 32'd33, 5'd7, 1'b1));
        q0.push_back(mk(32'hFFFF_FFFF, 32'h1_0000, 5'd7, 1'b1));
        q0.push_back(mk(32'h0, 32'hCAFE_F00D, 5'd8, 1'b0));
        drain();

        // Reset while an op sits in EXEC: it must never respond, and r0 wins first after
        begin
            int n = 0;
            q0.push_back(mk(32'd3, 32'd4, 5'd1, 1'b1));
            while (q0.size() > 0 && n < 50) begin
                cycle();
                n++;
            end
            if (n >= 50) to_flag++;
        end
        #2 rst_n = 1'b0;
        q0.delete();
        q1.delete();
        r0_valid = 1'b0;
        r1_valid = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        q0.push_back(rand_op());
        q1.push_back(rand_op());
        drain();

        // Random traffic with a stalling consumer
        rdy_pct = 70;
        repeat (400) begin
            if (q0.size() == 0 && $urandom_range(0, 2) == 0) q0.push_back(rand_op());
            if (q1.size() == 0 && $urandom_range(0, 2) == 0) q1.push_back(rand_op());
            cycle();
        end
        rdy_pct = 100;
        drain();

        repeat (3) @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
